// File: rtl/pri_encode_pkg.sv
// Shared types and helpers for the pri_encode_n priority encoder.
// Holds the output FSM state encoding and a popcount helper.
package pri_encode_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   localparam int MAX_N = 64;

   // Callers zero-extend their request vector to MAX_N bits.
   function automatic logic [6:0] popcount(input logic [MAX_N-1:0] v);
      logic [6:0] c;
      c = '0;
      for (int i = 0; i < MAX_N; i++) begin
         c = c + 7'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/pri_encode_core.sv
// Combinational wrap-around priority search: starts at 'start', descends
// with wrap, and reports the first set request as 'index' (hit = any set).
module pri_encode_core #(
   parameter  int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] x,
   input  logic [W-1:0] start,
   output logic [W-1:0] index,
   output logic         hit
);

   logic [N-1:0] rot;
   logic [W-1:0] rot_idx [N];

   // rot[gi] is the request visited gi steps after 'start' in the search order.
   for (genvar gi = 0; gi < N; gi++) begin : g_rot
      logic [W:0] diff;
      logic [W:0] wrapped;
      assign diff       = {1'b0, start} + (W+1)'(N) - (W+1)'(gi);
      assign wrapped    = (diff >= (W+1)'(N)) ? diff - (W+1)'(N) : diff;
      assign rot_idx[gi] = wrapped[W-1:0];
      assign rot[gi]     = x[wrapped[W-1:0]];
   end

   always_comb begin
      index = '0;
      hit   = 1'b0;
      for (int i = N-1; i >= 0; i--) begin
         if (rot[i]) begin
            index = rot_idx[i];
            hit   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pri_encode_n.sv
// Registered N-bit priority encoder with valid/ready output handshake.
// Define PRI_ENCODE_RR_EN for round-robin arbitration instead of fixed priority.
module pri_encode_n
   import pri_encode_pkg::*;
#(
   parameter  int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [N-1:0] x,
   input  logic         out_ready,
   output logic         valid,
   output logic [W-1:0] y,
   output logic [W:0]   cnt,
   output logic         idc
);

   state_t         state_reg, state_next;
   logic [W-1:0]   y_reg;
   logic [W:0]     cnt_reg;
   logic           idc_reg;
   logic [W-1:0]   start;
   logic [W-1:0]   win;
   logic           hit;
   logic           capture;
   logic [MAX_N-1:0] x_ext;

`ifdef PRI_ENCODE_RR_EN
   logic [W-1:0] p_reg;

   // Search begins just below the last winner, so it gets lowest priority.
   assign start = (p_reg == '0) ? W'(N-1) : p_reg - W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         p_reg <= '0;
      end else if (capture) begin
         p_reg <= win;
      end
   end
`else
   assign start = W'(N-1);
`endif

   pri_encode_core #(.N(N)) u_core (
      .x     (x),
      .start (start),
      .index (win),
      .hit   (hit)
   );

   always_comb begin
      x_ext        = '0;
      x_ext[N-1:0] = x;
   end

   // A new result may enter when the slot is empty or being drained this cycle.
   assign capture = en && hit && ((state_reg == EMPTY) || out_ready);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         EMPTY: if (capture) state_next = FULL;
         FULL:  if (out_ready && !capture) state_next = EMPTY;
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= EMPTY;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y_reg   <= '0;
         cnt_reg <= '0;
         idc_reg <= 1'b0;
      end else begin
         if (capture) begin
            y_reg   <= win;
            cnt_reg <= (W+1)'(popcount(x_ext));
         end
         if (en) begin
            idc_reg <= hit;
         end
      end
   end

   assign valid = (state_reg == FULL);
   assign y     = y_reg;
   assign cnt   = cnt_reg;
   assign idc   = idc_reg;

endmodule

// File: tb/tb_pri_encode_n.sv
// Directed + random bench for pri_encode_n (N=8 scoreboarded, N=16 directed,
// and N=4 round-robin when PRI_ENCODE_RR_EN is defined).
module tb_pri_encode_n;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // N=8 instance
   logic       rst8 = 1'b1, en8 = 1'b0, rdy8 = 1'b0;
   logic [7:0] x8 = '0;
   logic       v8, idc8;
   logic [2:0] y8;
   logic [3:0] cnt8;

   pri_encode_n #(.N(8)) dut8 (
      .clk(clk), .rst(rst8), .en(en8), .x(x8), .out_ready(rdy8),
      .valid(v8), .y(y8), .cnt(cnt8), .idc(idc8)
   );

   // N=16 instance
   logic        rst16 = 1'b1, en16 = 1'b0, rdy16 = 1'b0;
   logic [15:0] x16 = '0;
   logic        v16, idc16;
   logic [3:0]  y16;
   logic [4:0]  cnt16;

   pri_encode_n #(.N(16)) dut16 (
      .clk(clk), .rst(rst16), .en(en16), .x(x16), .out_ready(rdy16),
      .valid(v16), .y(y16), .cnt(cnt16), .idc(idc16)
   );

`ifdef PRI_ENCODE_RR_EN
   logic       rst4 = 1'b1, en4 = 1'b0, rdy4 = 1'b0;
   logic [3:0] x4 = '0;
   logic       v4, idc4;
   logic [1:0] y4;
   logic [2:0] cnt4;

   pri_encode_n #(.N(4)) dut4 (
      .clk(clk), .rst(rst4), .en(en4), .x(x4), .out_ready(rdy4),
      .valid(v4), .y(y4), .cnt(cnt4), .idc(idc4)
   );
`endif

   typedef struct {
      logic       v;
      logic [2:0] y;
      logic [3:0] cnt;
      logic       idc;
   } exp_t;

   exp_t exp_q[$];

   // Reference state for the N=8 instance
   logic       m_v = 1'b0, m_idc = 1'b0;
   logic [2:0] m_y = '0;
   logic [3:0] m_cnt = '0;
   int         m_p = 0;

   function automatic int pick8(logic [7:0] v, int p);
`ifdef PRI_ENCODE_RR_EN
      for (int k = 1; k <= 8; k++) begin
         int i;
         i = (p - k + 8) % 8;
         if (v[i]) return i;
      end
`else
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) return i;
      end
`endif
      return 0;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Drive one cycle on the N=8 instance, push model prediction, then compare.
   task automatic cyc8(logic r, logic e, logic [7:0] xv, logic rd);
      exp_t ex;
      logic cap;
      rst8 = r; en8 = e; x8 = xv; rdy8 = rd;
      if (r) begin
         m_v = 0; m_y = 0; m_cnt = 0; m_idc = 0; m_p = 0;
      end else begin
         cap = e && (xv != 0) && (!m_v || rd);
         if (cap) begin
            m_y   = 3'(pick8(xv, m_p));
            m_cnt = 4'($countones(xv));
            m_v   = 1'b1;
            m_p   = int'(m_y);
         end else if (m_v && rd) begin
            m_v = 1'b0;
         end
         if (e) m_idc = (xv != 0);
      end
      ex.v = m_v; ex.y = m_y; ex.cnt = m_cnt; ex.idc = m_idc;
      exp_q.push_back(ex);
      @(posedge clk);
      #1;
      ex = exp_q.pop_front();
      chk("valid8", 32'(v8), 32'(ex.v));
      chk("idc8",   32'(idc8), 32'(ex.idc));
      if (ex.v) begin
         chk("y8",   32'(y8),   32'(ex.y));
         chk("cnt8", 32'(cnt8), 32'(ex.cnt));
      end
      $display("t=%0t rst=%0b en=%0b x=%02h rdy=%0b -> valid=%0b y=%0d cnt=%0d idc=%0b",
               $time, r, e, xv, rd, v8, y8, cnt8, idc8);
   endtask

   initial begin
      // Reset state
      cyc8(1, 1, 8'hFF, 1);
      cyc8(1, 0, 8'h00, 0);
      chk("rst_y8",   32'(y8),   0);
      chk("rst_cnt8", 32'(cnt8), 0);

      // First capture: highest set index 5, three bits set
      cyc8(0, 1, 8'b0010_0110, 1);
      chk("cap_valid", 32'(v8),   1);
      chk("cap_y",     32'(y8),   5);
      chk("cap_cnt",   32'(cnt8), 3);
      chk("cap_idc",   32'(idc8), 1);

      // Backpressure holds the result while x changes
      cyc8(0, 1, 8'h80, 0);
      cyc8(0, 1, 8'h80, 0);
      chk("hold_y",     32'(y8), 5);
      chk("hold_valid", 32'(v8), 1);
      cyc8(0, 1, 8'h80, 1);
      chk("after_hold_y", 32'(y8), 7);

      // Drain with en low, then x=0 and blocked capture
      cyc8(0, 0, 8'h00, 1);
      chk("drain_valid", 32'(v8), 0);
      cyc8(0, 1, 8'h00, 1);
      chk("zero_idc", 32'(idc8), 0);
      cyc8(0, 0, 8'hFF, 1);
      chk("blocked_valid", 32'(v8), 0);
      chk("blocked_idc",   32'(idc8), 0);

      // Full vector popcount and reset while FULL
      cyc8(0, 1, 8'hFF, 0);
      chk("full_cnt", 32'(cnt8), 8);
      cyc8(0, 0, 8'h00, 0);
      cyc8(1, 1, 8'hFF, 0);
      chk("rstfull_valid", 32'(v8),   0);
      chk("rstfull_y",     32'(y8),   0);
      chk("rstfull_cnt",   32'(cnt8), 0);

      // Random traffic through the scoreboard
      for (int i = 0; i < 60; i++) begin
         cyc8(($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1,
              8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)),
              $urandom_range(0, 2) != 0);
      end

      // N=16: back-to-back results with valid held high
      @(posedge clk); #1;
      rst16 = 0; en16 = 1; x16 = 16'h0001; rdy16 = 1;
      @(posedge clk); #1;
      chk("n16_valid0", 32'(v16), 1);
      chk("n16_y0",     32'(y16), 0);
      $display("t=%0t n16 x=0001 -> valid=%0b y=%0d", $time, v16, y16);
      x16 = 16'h8001;
      @(posedge clk); #1;
      chk("n16_valid1", 32'(v16),   1);
      chk("n16_y1",     32'(y16),   15);
      chk("n16_cnt1",   32'(cnt16), 2);
      $display("t=%0t n16 x=8001 -> valid=%0b y=%0d", $time, v16, y16);

`ifdef PRI_ENCODE_RR_EN
      begin
         logic [1:0] rr_exp [5];
         rr_exp = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
         @(posedge clk); #1;
         rst4 = 0; en4 = 1; x4 = 4'hF; rdy4 = 1;
         for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("rr4_valid", 32'(v4), 1);
            chk("rr4_y",     32'(y4), 32'(rr_exp[i]));
            $display("t=%0t rr4 step=%0d -> y=%0d", $time, i, y4);
         end
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pri_encode_n.md
PRI_ENCODE_N -- requirements
Module: pri_encode_n

Interface
REQ-001 The module SHALL have parameter N, default 8, meaning the request vector width; legal range 2..64.
REQ-002 The module SHALL have derived localparam W = $clog2(N), meaning the index width.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 The module SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 The module SHALL have port en, input, 1, capture enable.
REQ-006 The module SHALL have port x, input, N, request vector.
REQ-007 The module SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-008 The module SHALL have port valid, output, 1, result held in the output register.
REQ-009 The module SHALL have port y, output, W, encoded index of the winning request.
REQ-010 The module SHALL have port cnt, output, W+1, popcount of the captured x.
REQ-011 The module SHALL have port idc, output, 1, registered "x != 0" status, updated every enabled cycle.

Function
REQ-012 Fixed priority SHALL be highest set index wins (x[N-1] highest).
REQ-013 The two-state FSM SHALL have states EMPTY (valid=0) and FULL (valid=1).
REQ-014 EMPTY -> FULL SHALL occur when en=1 and x!=0, capturing y and cnt; latency from x to valid is 1 cycle.
REQ-015 In FULL with out_ready=1: if en=1 and x!=0, a new result SHALL be captured in the same cycle (stay FULL, back-to-back, one result per cycle); else the FSM SHALL go to EMPTY.
REQ-016 In FULL with out_ready=0, y, cnt and valid SHALL hold stable regardless of en and x.
REQ-017 idc SHALL be loaded with (x != 0) on every cycle with en=1 and hold its value when en=0, independent of the handshake.
REQ-018 en=0 SHALL block new captures only; a pending result SHALL still drain via out_ready.
REQ-019 x=0 with en=1 SHALL NOT capture a result; idc becomes 0.
REQ-020 cnt SHALL equal the number of set bits of x in the capture cycle; the value N SHALL be representable (no wrap).

Reset
REQ-021 While rst=1 at a rising edge, state SHALL be EMPTY, valid=0, y=0, cnt=0, idc=0, and the rotate pointer SHALL be 0.
REQ-022 Reset SHALL take priority over en and out_ready, and a result held mid-handshake SHALL be discarded.

Configuration
REQ-023 Macro PRI_ENCODE_RR_EN SHALL select round-robin arbitration when defined.
REQ-024 With PRI_ENCODE_RR_EN defined, a W-bit pointer p SHALL be kept; the search SHALL start at index p-1 and descend with wrap (p-1, p-2, ..., 0, N-1, ..., p).
REQ-025 With PRI_ENCODE_RR_EN defined, p SHALL update to the captured y on each capture, so the last winner becomes lowest priority next time.
REQ-026 Without PRI_ENCODE_RR_EN, the fixed priority of REQ-012 SHALL apply and no pointer register SHALL exist.

Structure
REQ-027 Package pri_encode_pkg SHALL hold the FSM state enum (EMPTY, FULL) and the popcount function.
REQ-028 The block SHALL use one sub-module, pri_encode_core: combinational, with parameter N and inputs x and start index, and outputs index and hit; in fixed mode it is tied to start index N-1.
REQ-029 Output registers SHALL live only in pri_encode_n.

Verification
REQ-030 (N=8) After rst, en=1, x=8'b0010_0110, out_ready=1 -> next cycle valid=1, y=5, cnt=3, idc=1.
REQ-031 (N=8) FULL holding y=5, out_ready=0, x changes to 8'h80 -> y stays 5 and valid stays 1 until out_ready=1; the next cycle then gives y=7.
REQ-032 (N=8) en=1, x=0 -> valid=0 and idc=0; then en=0, x=8'hFF -> no capture and idc stays 0.
REQ-033 (N=8) x=8'hFF captured -> cnt=8 (4'b1000) with no overflow; assert rst during FULL -> the next cycle gives valid=0, y=0, cnt=0.
REQ-034 (RR, N=4) x=4'b1111 held, out_ready=1 -> y sequence 3, 2, 1, 0, 3 on consecutive cycles.
REQ-035 (Fixed, N=16) x=16'h0001 then 16'h8001 -> y=0 then y=15, back-to-back with valid held at 1.
